mem_access_stage: RTL and testbench
===================================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 The block SHALL have these ports, clock and reset first: clk  in  1  clock, all state updates on posedge.
REQ-002 reset  in  1  synchronous, active-high; clock clk.
REQ-003 MemRead  in  3  load type from exe_mem: 000 none, 001 lw, 010 lb, 011 lbu, 100 lh, 101 lhu; 110/111 treated as none.
REQ-004 MemWrite  in  2  store type from exe_mem: 00 none, 01 sw, 10 sb, 11 sh.
REQ-005 Aluout  in  32  effective address, or pass-through result when no load.
REQ-006 busB  in  32  store data, right-aligned.
REQ-007 dmem_req  out  1  registered memory request.
REQ-008 dmem_we  out  1  1 = write request.
REQ-009 dmem_addr  out  32  word address: {Aluout[31:2],2'b00}, latched.
REQ-010 dmem_be  out  4  byte enables, bit i = byte i (little-endian).
REQ-011 dmem_wdata  out  32  lane-replicated store data.
REQ-012 dmem_ack  in  1  one-cycle completion pulse from memory.
REQ-013 dmem_rdata  in  32  read word, valid when dmem_ack=1.
REQ-014 mem_stall  out  1  combinational; 1 holds exe_mem and all upstream stages.
REQ-015 mem_result  out  32  data to mem_wb: extended load data if load completed, else Aluout.
REQ-016 addr_exc  out  1  misaligned-access exception pulse; exc_code  out  5  4 = AdEL, 5 = AdES; badvaddr  out  32  faulting Aluout.

Function
REQ-017 Access present SHALL mean MemRead in {001..101} or MemWrite != 00; both non-zero SHALL be treated as load-only.
REQ-018 Misaligned SHALL mean: lw/sw with Aluout[1:0]!=0; lh/lhu/sh with Aluout[0]!=0; byte ops never misaligned.
REQ-019 FSM SHALL have states IDLE, BUSY, DONE; reset state IDLE.
REQ-020 IDLE, aligned access present: mem_stall=1 combinationally; next edge -> BUSY with dmem_req=1 and dmem_we, dmem_addr, dmem_be, dmem_wdata latched.
REQ-021 IDLE, misaligned access: no request; addr_exc=1, exc_code, badvaddr valid in the same cycle; mem_stall=0; state stays IDLE.
REQ-022 BUSY: mem_stall=1, dmem_req=1 and latched fields held stable until dmem_ack=1.
REQ-023 BUSY with dmem_ack=1: next edge -> DONE, dmem_req=0, load word extracted per latched type/offset and registered into load_data.
REQ-024 DONE: mem_stall=0 for exactly one cycle; mem_result=load_data for loads; no new access started from the still-present instruction; next edge -> IDLE.
REQ-025 Minimum access latency SHALL be 3 cycles (IDLE accept, BUSY with ack, DONE); each extra ack-wait cycle adds one.
REQ-026 Byte enables: sw 1111; sh offset0 0011, offset2 1100; sb 0001<<Aluout[1:0]; loads 0000 with dmem_we=0.
REQ-027 wdata: sw busB; sh {2{busB[15:0]}}; sb {4{busB[7:0]}}.
REQ-028 Load extraction: lb/lbu select byte Aluout[1:0], sign/zero extend; lh/lhu select half Aluout[1], sign/zero extend; lw whole word.
REQ-029 dmem_ack outside BUSY SHALL be ignored.
REQ-030 No access present in IDLE: mem_stall=0, mem_result=Aluout, addr_exc=0.

Reset
REQ-031 reset SHALL force state IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_be=0, dmem_wdata=0, load_data=0, with priority over all other inputs.
REQ-032 Reset in BUSY SHALL drop dmem_req next cycle; a late dmem_ack SHALL be ignored per REQ-029.
REQ-033 addr_exc, exc_code, badvaddr SHALL be 0 whenever reset=1.

Verification
REQ-034 lw Aluout=0x100, ack 2 cycles after req, rdata=0xDEADBEEF -> stall high 4 cycles, be=1111, mem_result=0xDEADBEEF in DONE.
REQ-035 lb Aluout=0x103, rdata=0x80FF0000 -> mem_result=0xFFFFFF80; lbu same -> 0x00000080.
REQ-036 sh Aluout=0x202, busB=0x1234ABCD -> dmem_we=1, be=1100, wdata=0xABCDABCD, addr=0x200.
REQ-037 lw Aluout=0x101 -> no dmem_req, addr_exc=1, exc_code=4, badvaddr=0x101, stall=0; sh 0x203 -> exc_code=5.
REQ-038 reset asserted in BUSY, ack arrives next cycle -> dmem_req=0, state IDLE, mem_result=Aluout, no DONE cycle.
REQ-039 Back-to-back sw then lw -> each gets separate request; no request issued during DONE.

Source files
------------

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_stage
// Brief   : MEM pipeline stage; issues one data-memory access per load/store,
//           stalls upstream until the response arrives, flags misalignment.
// Revision: 1.0
// ============================================================================
module mem_access_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  MemRead,
    input  logic [1:0]  MemWrite,
    input  logic [31:0] Aluout,
    input  logic [31:0] busB,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic [31:0] mem_result,
    output logic        addr_exc,
    output logic [4:0]  exc_code,
    output logic [31:0] badvaddr
);

    localparam logic [2:0] LD_LW  = 3'b001;
    localparam logic [2:0] LD_LB  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b011;
    localparam logic [2:0] LD_LH  = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    localparam logic [1:0] ST_SW  = 2'b01;
    localparam logic [1:0] ST_SB  = 2'b10;
    localparam logic [1:0] ST_SH  = 2'b11;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [2:0]  ld_type_q;
    logic [1:0]  off_q;
    logic        is_load_q;
    logic [31:0] load_data_q;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_misaligned;
    logic        w_start;
    logic        w_exc;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_d;

    // A load takes precedence when both load and store codes are non-zero.
    always_comb begin
        w_is_load    = (MemRead != 3'b000) && (MemRead <= LD_LHU);
        w_is_store   = !w_is_load && (MemWrite != 2'b00);
        w_misaligned = 1'b0;
        if (w_is_load) begin
            case (MemRead)
                LD_LW:          w_misaligned = |Aluout[1:0];
                LD_LH, LD_LHU:  w_misaligned = Aluout[0];
                default:        w_misaligned = 1'b0;
            endcase
        end else if (w_is_store) begin
            case (MemWrite)
                ST_SW:   w_misaligned = |Aluout[1:0];
                ST_SH:   w_misaligned = Aluout[0];
                default: w_misaligned = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = 32'h0;
        if (w_is_store) begin
            case (MemWrite)
                ST_SW: begin
                    w_be    = 4'b1111;
                    w_wdata = busB;
                end
                ST_SH: begin
                    w_be    = Aluout[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{busB[15:0]}};
                end
                ST_SB: begin
                    w_be    = 4'b0001 << Aluout[1:0];
                    w_wdata = {4{busB[7:0]}};
                end
                default: begin
                    w_be    = 4'b0000;
                    w_wdata = 32'h0;
                end
            endcase
        end
    end

    // Extraction uses the latched type/offset, since dmem_addr is word-aligned.
    always_comb begin
        w_byte   = dmem_rdata[{off_q, 3'b000} +: 8];
        w_half   = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        w_load_d = 32'h0;
        case (ld_type_q)
            LD_LW:   w_load_d = dmem_rdata;
            LD_LB:   w_load_d = {{24{w_byte[7]}}, w_byte};
            LD_LBU:  w_load_d = {24'h0, w_byte};
            LD_LH:   w_load_d = {{16{w_half[15]}}, w_half};
            LD_LHU:  w_load_d = {16'h0, w_half};
            default: w_load_d = 32'h0;
        endcase
    end

    assign w_start = (state_q == S_IDLE) && (w_is_load || w_is_store) && !w_misaligned;
    assign w_exc   = !reset && (state_q == S_IDLE) && (w_is_load || w_is_store) && w_misaligned;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= 32'h0;
            dmem_be     <= 4'b0000;
            dmem_wdata  <= 32'h0;
            load_data_q <= 32'h0;
            ld_type_q   <= 3'b000;
            off_q       <= 2'b00;
            is_load_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_start) begin
                        state_q    <= S_BUSY;
                        dmem_req   <= 1'b1;
                        dmem_we    <= w_is_store;
                        dmem_addr  <= {Aluout[31:2], 2'b00};
                        dmem_be    <= w_be;
                        dmem_wdata <= w_wdata;
                        ld_type_q  <= w_is_load ? MemRead : 3'b000;
                        off_q      <= Aluout[1:0];
                        is_load_q  <= w_is_load;
                    end
                end
                S_BUSY: begin
                    if (dmem_ack) begin
                        state_q     <= S_DONE;
                        dmem_req    <= 1'b0;
                        load_data_q <= w_load_d;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q  <= S_IDLE;
                    dmem_req <= 1'b0;
                end
            endcase
        end
    end

    assign mem_stall  = w_start || (state_q == S_BUSY);
    assign mem_result = ((state_q == S_DONE) && is_load_q) ? load_data_q : Aluout;
    assign addr_exc   = w_exc;
    assign exc_code   = w_exc ? (w_is_load ? EXC_ADEL : EXC_ADES) : 5'd0;
    assign badvaddr   = w_exc ? Aluout : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_access_stage
// Brief   : Directed and random load/store traffic against a reference model.
// Revision: 1.0
// ============================================================================
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  MemRead;
    logic [1:0]  MemWrite;
    logic [31:0] Aluout;
    logic [31:0] busB;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        mem_stall;
    logic [31:0] mem_result;
    logic        addr_exc;
    logic [4:0]  exc_code;
    logic [31:0] badvaddr;

    int n_checks = 0;
    int n_errors = 0;

    mem_access_stage u_dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Aluout     (Aluout),
        .busB       (busB),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .mem_stall  (mem_stall),
        .mem_result (mem_result),
        .addr_exc   (addr_exc),
        .exc_code   (exc_code),
        .badvaddr   (badvaddr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Access size in bytes; 0 means no access of that kind.
    function automatic int ld_size(input logic [2:0] mr);
        case (mr)
            3'd1:       return 4;
            3'd2, 3'd3: return 1;
            3'd4, 3'd5: return 2;
            default:    return 0;
        endcase
    endfunction

    function automatic int st_size(input logic [1:0] mw);
        case (mw)
            2'd1:    return 4;
            2'd2:    return 1;
            2'd3:    return 2;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] mr, input int off,
                                               input logic [31:0] rdata);
        int          sz;
        logic [63:0] mask;
        logic [31:0] v;
        sz   = ld_size(mr);
        mask = (64'd1 << (8 * sz)) - 64'd1;
        v    = (rdata >> (8 * off)) & mask[31:0];
        if ((mr == 3'd2 || mr == 3'd4) && v[8 * sz - 1])
            v = v | ~mask[31:0];
        return v;
    endfunction

    function automatic logic [31:0] model_wdata(input int sz, input logic [31:0] bb);
        logic [31:0] w;
        w = 32'h0;
        for (int i = 0; i < 4; i++)
            w[8 * i +: 8] = bb[8 * (i % sz) +: 8];
        return w;
    endfunction

    task automatic run_access(input logic [2:0] mr, input logic [1:0] mw,
                              input logic [31:0] alu, input logic [31:0] bb,
                              input int delay, input logic [31:0] rdata);
        bit          ld;
        int          sz;
        int          off;
        int          stall_cnt;
        logic [3:0]  exp_be;
        logic [31:0] exp_res;
        ld  = ld_size(mr) != 0;
        sz  = ld ? ld_size(mr) : st_size(mw);
        off = int'(alu[1:0]);

        @(negedge clk);
        MemRead  = mr;
        MemWrite = mw;
        Aluout   = alu;
        busB     = bb;
        dmem_ack = 1'b0;
        #1;
        check("req_in_idle", dmem_req, 0);

        if (sz == 0) begin
            check("noacc_stall", mem_stall, 0);
            check("noacc_result", mem_result, alu);
            check("noacc_exc", addr_exc, 0);
            dmem_ack = 1'b1;
            return;
        end

        if (off % sz != 0) begin
            check("mis_stall", mem_stall, 0);
            check("mis_exc", addr_exc, 1);
            check("mis_code", exc_code, ld ? 32'd4 : 32'd5);
            check("mis_badv", badvaddr, alu);
            check("mis_result", mem_result, alu);
            @(negedge clk);
            MemRead  = 3'd0;
            MemWrite = 2'd0;
            #1;
            check("mis_noreq", dmem_req, 0);
            return;
        end

        check("acc_stall_idle", mem_stall, 1);
        check("acc_exc", addr_exc, 0);
        exp_be    = ld ? 4'b0000 : 4'(((1 << sz) - 1) << off);
        stall_cnt = 1;
        for (int w = 0; w <= delay; w++) begin
            @(negedge clk);
            dmem_ack   = (w == delay);
            dmem_rdata = (w == delay) ? rdata : $urandom;
            #1;
            check("busy_req", dmem_req, 1);
            if (mem_stall) stall_cnt++;
            if (w == 0) begin
                check("busy_we", dmem_we, ld ? 0 : 1);
                check("busy_addr", dmem_addr, {alu[31:2], 2'b00});
                check("busy_be", dmem_be, exp_be);
                if (!ld) check("busy_wdata", dmem_wdata, model_wdata(sz, bb));
            end
        end
        @(negedge clk);
        dmem_ack   = 1'b0;
        dmem_rdata = $urandom;
        #1;
        exp_res = ld ? model_load(mr, off, rdata) : alu;
        check("done_stall", mem_stall, 0);
        check("done_req", dmem_req, 0);
        check("done_result", mem_result, exp_res);
        check("stall_cycles", stall_cnt, delay + 2);
    endtask

    initial begin
        reset      = 1'b1;
        MemRead    = 3'd1;
        MemWrite   = 2'd0;
        Aluout     = 32'h0000_0101;
        busB       = 32'h0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req", dmem_req, 0);
        check("rst_we", dmem_we, 0);
        check("rst_addr", dmem_addr, 0);
        check("rst_be", dmem_be, 0);
        check("rst_wdata", dmem_wdata, 0);
        check("rst_exc", addr_exc, 0);
        check("rst_code", exc_code, 0);
        check("rst_badv", badvaddr, 0);
        MemRead = 3'd0;
        @(negedge clk);
        reset = 1'b0;

        // Directed scenarios
        run_access(3'd1, 2'd0, 32'h0000_0100, 32'h0, 2, 32'hDEAD_BEEF);
        run_access(3'd2, 2'd0, 32'h0000_0103, 32'h0, 0, 32'h80FF_0000);
        check("lb_sign", mem_result, 32'hFFFF_FF80);
        run_access(3'd3, 2'd0, 32'h0000_0103, 32'h0, 1, 32'h80FF_0000);
        check("lbu_zero", mem_result, 32'h0000_0080);
        run_access(3'd0, 2'd3, 32'h0000_0202, 32'h1234_ABCD, 0, 32'h0);
        run_access(3'd1, 2'd0, 32'h0000_0101, 32'h0, 0, 32'h0);
        run_access(3'd0, 2'd3, 32'h0000_0203, 32'h0, 0, 32'h0);
        run_access(3'd0, 2'd1, 32'h0000_0400, 32'hCAFE_F00D, 1, 32'h0);
        run_access(3'd1, 2'd0, 32'h0000_0404, 32'h0, 0, 32'h1357_9BDF);
        run_access(3'd5, 2'd1, 32'h0000_0502, 32'h5555_AAAA, 0, 32'h8001_7FFE);
        run_access(3'd7, 2'd0, 32'h0000_0603, 32'h0, 0, 32'h0);

        // Reset while waiting for the memory response
        @(negedge clk);
        MemRead  = 3'd1;
        MemWrite = 2'd0;
        Aluout   = 32'h0000_0300;
        dmem_ack = 1'b0;
        @(negedge clk);
        #1;
        check("rb_busy_req", dmem_req, 1);
        reset = 1'b1;
        #1;
        check("rb_exc_in_rst", addr_exc, 0);
        @(negedge clk);
        reset      = 1'b0;
        MemRead    = 3'd0;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1111_2222;
        #1;
        check("rb_req_dropped", dmem_req, 0);
        check("rb_stall", mem_stall, 0);
        check("rb_result", mem_result, 32'h0000_0300);
        @(negedge clk);
        dmem_ack = 1'b0;
        #1;
        check("rb_no_done_req", dmem_req, 0);
        check("rb_no_done_result", mem_result, 32'h0000_0300);

        // Random traffic
        for (int n = 0; n < 80; n++) begin
            run_access(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                       $urandom, $urandom, $urandom_range(0, 3), $urandom);
        end

        @(negedge clk);
        MemRead  = 3'd0;
        MemWrite = 2'd0;
        dmem_ack = 1'b0;
        #1;
        check("final_req", dmem_req, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
